reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//   Parametrised integer register file for the RISCky core: NREGS x XLEN storage,
//   NRD combinational read ports, one write port, x0 hardwired to zero.
//   Carries a per-register busy scoreboard: the decoder marks destinations on issue,
//   writeback clears them. Sits between decode (reads, issue) and writeback (write).
// PARAMETERS
//   XLEN    32  data width in bits
//   NREGS   32  number of architectural registers (power of two, >= 2)
//   NRD     2   number of read ports
//   BYPASS  1   1: same-cycle write data forwarded to matching read ports; 0: old value
//   AW      $clog2(NREGS)  register address width (derived, do not override)
// PORTS
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous, active-low reset
//   raddr        in   NRD*AW     read addresses, port i at [i*AW +: AW]
//   rdata        out  NRD*XLEN   read data, port i at [i*XLEN +: XLEN]
//   rbusy        out  NRD        port i source is pending (hazard)
//   we           in   1          writeback strobe
//   waddr        in   AW         writeback destination
//   wdata        in   XLEN       writeback data
//   issue_valid  in   1          instruction issued with a destination this cycle
//   issue_rd     in   AW         destination of issuing instruction
//   flush        in   1          clear all busy bits (pipeline flush)
//   busy_cnt     out  AW+1       number of registers currently busy
// BEHAVIOUR
//   - Reset (reset==0, async): all registers, all busy bits and busy_cnt = 0.
//     rdata therefore reads 0 on every port during/after reset.
//   - Write: at posedge, if we && waddr!=0, regs[waddr] <= wdata. Writes to x0 dropped.
//   - Read: combinational, zero latency. raddr==0 -> rdata=0 always.
//     BYPASS=1 and we && waddr==raddr_i && raddr_i!=0 -> rdata_i = wdata (same cycle).
//     Otherwise rdata_i = regs[raddr_i]. BYPASS=0 -> new value visible next cycle.
//   - Scoreboard, evaluated per register r at posedge, priority order:
//       1. flush             -> busy[r] <= 0 (issue in same cycle ignored)
//       2. issue_valid && issue_rd==r && r!=0 -> busy[r] <= 1 (beats same-cycle clear)
//       3. we && waddr==r    -> busy[r] <= 0
//     busy[0] is constant 0. Write to a non-busy reg is legal; data still written.
//   - rbusy_i = busy[raddr_i] && !(BYPASS && we && waddr==raddr_i); rbusy_i=0 for x0.
//     Decode stalls on any rbusy; block itself never stalls or back-pressures.
//   - busy_cnt = popcount(busy), registered, updated each cycle with the busy vector;
//     max value NREGS-1 (x0 excluded), never wraps.
//   - Reset asserted mid-operation aborts everything; pending writes are lost.
// STRUCTURE
//   - riscky_pkg: XLEN default, REG_ZERO (=0), NREGS default, reg address width.
//   - Sub-module rf_scoreboard: busy vector, priority update, busy_cnt, rbusy logic.
//   - Top holds storage array, write decode, read muxes and bypass; generate loop over NRD.
// TESTING
//   1. Reset low mid-run with x5=0xDEADBEEF -> all rdata=0, rbusy=0, busy_cnt=0.
//   2. we=1,waddr=0,wdata=0xFFFFFFFF; read x0 same and next cycle -> rdata=0.
//   3. BYPASS=1: write x7=0x1234 while raddr0=7 -> rdata0=0x1234 same cycle;
//      BYPASS=0 -> old value, 0x1234 next cycle.
//   4. issue x3; next cycle raddr1=3 -> rbusy1=1, busy_cnt=1; we x3 -> busy clears,
//      rbusy1=0 in write cycle when BYPASS=1.
//   5. Same cycle issue_rd=9 and we waddr=9 -> busy[9]=1 afterwards, regs[9]=wdata.
//   6. Issue x1..x31 over 31 cycles -> busy_cnt=31; flush with issue_valid -> busy_cnt=0.
//   Run with NREGS=16, NRD=3, XLEN=64 in addition to defaults.

Source files
------------

// File: rtl/reg_file_scoreboard_pkg.sv
// ============================================================================
// Module : reg_file_scoreboard_pkg
// Brief  : Shared defaults and busy-bit update encoding for the register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package reg_file_scoreboard_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef enum logic [1:0] {
    SB_HOLD = 2'd0,
    SB_SET  = 2'd1,
    SB_CLR  = 2'd2
  } sb_op_e;

  // Flush dominates issue, and issue dominates a same-cycle writeback clear.
  function automatic sb_op_e sb_op(input logic flush, input logic set, input logic clr);
    if (flush)    return SB_CLR;
    else if (set) return SB_SET;
    else if (clr) return SB_CLR;
    else          return SB_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard_sb.sv
// ============================================================================
// Module : rf_scoreboard
// Brief  : Per-register busy vector, registered busy count and read hazards.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] i_raddr,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic              i_issue_valid,
  input  logic [AW-1:0]     i_issue_rd,
  input  logic              i_flush,
  output logic [NRD-1:0]    o_rbusy,
  output logic [AW:0]       o_busy_cnt
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      r_busy_cnt;
  logic [AW:0]      w_cnt_nxt;

  always_comb begin
    w_busy_nxt           = r_busy;
    w_busy_nxt[REG_ZERO] = 1'b0;
    w_cnt_nxt            = '0;
    for (int r = 1; r < NREGS; r++) begin
      case (sb_op(i_flush,
                  i_issue_valid && (i_issue_rd == AW'(r)),
                  i_we && (i_waddr == AW'(r))))
        SB_SET:  w_busy_nxt[r] = 1'b1;
        SB_CLR:  w_busy_nxt[r] = 1'b0;
        default: w_busy_nxt[r] = r_busy[r];
      endcase
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
    end
  end

  // Count is computed from the next-state vector so it tracks busy on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy_cnt = r_busy_cnt;

  for (genvar i = 0; i < NRD; i++) begin : g_rbusy
    logic [AW-1:0] w_addr;
    logic          w_fwd;
    assign w_addr     = i_raddr[i*AW +: AW];
    assign w_fwd      = (BYPASS != 0) && i_we && (i_waddr == w_addr);
    assign o_rbusy[i] = r_busy[w_addr] && !w_fwd && (w_addr != AW'(REG_ZERO));
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
// Module : reg_file_scoreboard
// Brief  : NREGS x XLEN integer register file, x0 hardwired, with busy scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]      o_rbusy,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [XLEN-1:0]     i_wdata,
  input  logic                i_issue_valid,
  input  logic [AW-1:0]       i_issue_rd,
  input  logic                i_flush,
  output logic [AW:0]         o_busy_cnt
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_waddr != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = i_raddr[i*AW +: AW];

    always_comb begin
      if (w_addr == AW'(REG_ZERO))
        o_rdata[i*XLEN +: XLEN] = '0;
      else if ((BYPASS != 0) && i_we && (i_waddr == w_addr))
        o_rdata[i*XLEN +: XLEN] = i_wdata;
      else
        o_rdata[i*XLEN +: XLEN] = r_regs[w_addr];
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_raddr       (i_raddr),
    .i_we          (i_we),
    .i_waddr       (i_waddr),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_flush       (i_flush),
    .o_rbusy       (o_rbusy),
    .o_busy_cnt    (o_busy_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
// ============================================================================
// Module : tb_reg_file_scoreboard
// Brief  : Queue-based checks of a default instance and a 16x64, 3-port, no-bypass one.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (XLEN=32, NREGS=32, NRD=2, BYPASS=1)
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_we, a_issue_valid, a_flush;
  logic [4:0]  a_waddr, a_issue_rd;
  logic [31:0] a_wdata;
  logic [5:0]  a_cnt;

  // Instance B: XLEN=64, NREGS=16, NRD=3, BYPASS=0
  logic [11:0]  b_raddr;
  logic [191:0] b_rdata;
  logic [2:0]   b_rbusy;
  logic         b_we, b_issue_valid, b_flush;
  logic [3:0]   b_waddr, b_issue_rd;
  logic [63:0]  b_wdata;
  logic [4:0]   b_cnt;

  reg_file_scoreboard u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_raddr(a_raddr), .o_rdata(a_rdata), .o_rbusy(a_rbusy),
    .i_we(a_we), .i_waddr(a_waddr), .i_wdata(a_wdata), .i_issue_valid(a_issue_valid),
    .i_issue_rd(a_issue_rd), .i_flush(a_flush), .o_busy_cnt(a_cnt)
  );

  reg_file_scoreboard #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_raddr(b_raddr), .o_rdata(b_rdata), .o_rbusy(b_rbusy),
    .i_we(b_we), .i_waddr(b_waddr), .i_wdata(b_wdata), .i_issue_valid(b_issue_valid),
    .i_issue_rd(b_issue_rd), .i_flush(b_flush), .o_busy_cnt(b_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [63:0] exp_q[$];

  localparam int A_RD0 = 0, A_RD1 = 1, A_RBUSY = 2, A_CNT = 3;
  localparam int B_RD0 = 4, B_RD1 = 5, B_RD2 = 6, B_RBUSY = 7, B_CNT = 8;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      A_RD0:   return {32'd0, a_rdata[31:0]};
      A_RD1:   return {32'd0, a_rdata[63:32]};
      A_RBUSY: return {62'd0, a_rbusy};
      A_CNT:   return {58'd0, a_cnt};
      B_RD0:   return b_rdata[63:0];
      B_RD1:   return b_rdata[127:64];
      B_RD2:   return b_rdata[191:128];
      B_RBUSY: return {61'd0, b_rbusy};
      B_CNT:   return {59'd0, b_cnt};
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      string       t;
      int          s;
      logic [63:0] e;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      chk(t, observe(s), e);
    end
  endtask

  task automatic check_neg();
    @(negedge clk);
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_we = 1'b0; a_issue_valid = 1'b0; a_flush = 1'b0;
    a_waddr = '0; a_wdata = '0; a_issue_rd = '0;
    b_we = 1'b0; b_issue_valid = 1'b0; b_flush = 1'b0;
    b_waddr = '0; b_wdata = '0; b_issue_rd = '0;
  endtask

  initial begin
    idle_all();
    rst_n   = 1'b0;
    a_raddr = {5'd3, 5'd5};
    b_raddr = {4'd1, 4'd2, 4'd3};
    repeat (2) @(posedge clk);
    #1;
    push("rst_a_rd0", A_RD0, 64'd0);
    push("rst_a_rd1", A_RD1, 64'd0);
    push("rst_a_rbusy", A_RBUSY, 64'd0);
    push("rst_a_cnt", A_CNT, 64'd0);
    push("rst_b_rd2", B_RD2, 64'd0);
    push("rst_b_cnt", B_CNT, 64'd0);
    check_neg();
    rst_n = 1'b1;
    tick();

    // Populate x5 and mark x6 busy, then pull reset asynchronously mid-cycle
    a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
    a_issue_valid = 1'b1; a_issue_rd = 5'd6;
    tick();
    idle_all();
    a_raddr = {5'd6, 5'd5};
    push("pre_rst_rd0", A_RD0, 64'hDEADBEEF);
    push("pre_rst_rbusy", A_RBUSY, 64'h2);
    push("pre_rst_cnt", A_CNT, 64'd1);
    check_neg();
    #2 rst_n = 1'b0;
    #1;
    push("mid_rst_rd0", A_RD0, 64'd0);
    push("mid_rst_rbusy", A_RBUSY, 64'd0);
    push("mid_rst_cnt", A_CNT, 64'd0);
    drain();
    #1 rst_n = 1'b1;
    tick();
    push("post_rst_rd0", A_RD0, 64'd0);
    check_neg();
    tick();

    // Writes to x0 are dropped
    a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF;
    a_raddr = {5'd0, 5'd0};
    push("x0_wr_rd0", A_RD0, 64'd0);
    push("x0_wr_rd1", A_RD1, 64'd0);
    check_neg();
    tick();
    idle_all();
    push("x0_next_rd0", A_RD0, 64'd0);
    check_neg();
    tick();

    // Same-cycle forwarding (A) versus next-cycle visibility (B)
    a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h1234; a_raddr = {5'd0, 5'd7};
    b_we = 1'b1; b_waddr = 4'd7; b_wdata = 64'h1234; b_raddr = {4'd7, 4'd7, 4'd7};
    push("byp_a_rd0", A_RD0, 64'h1234);
    push("nobyp_b_rd0", B_RD0, 64'd0);
    push("nobyp_b_rd2", B_RD2, 64'd0);
    check_neg();
    tick();
    idle_all();
    push("byp_a_next", A_RD0, 64'h1234);
    push("nobyp_b_next0", B_RD0, 64'h1234);
    push("nobyp_b_next1", B_RD1, 64'h1234);
    check_neg();
    tick();

    // Issue x3, observe hazard, then clear it by writeback
    a_issue_valid = 1'b1; a_issue_rd = 5'd3;
    b_issue_valid = 1'b1; b_issue_rd = 4'd3;
    push("iss_a_cnt", A_CNT, 64'd0);
    check_neg();
    tick();
    idle_all();
    a_raddr = {5'd3, 5'd0};
    b_raddr = {4'd0, 4'd3, 4'd0};
    push("haz_a_rbusy", A_RBUSY, 64'h2);
    push("haz_a_cnt", A_CNT, 64'd1);
    push("haz_b_rbusy", B_RBUSY, 64'h2);
    push("haz_b_cnt", B_CNT, 64'd1);
    check_neg();
    tick();
    a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
    b_we = 1'b1; b_waddr = 4'd3; b_wdata = 64'h33;
    push("wb_a_rbusy", A_RBUSY, 64'd0);
    push("wb_a_rd1", A_RD1, 64'h33);
    push("wb_a_cnt", A_CNT, 64'd1);
    push("wb_b_rbusy", B_RBUSY, 64'h2);
    push("wb_b_rd1", B_RD1, 64'd0);
    check_neg();
    tick();
    idle_all();
    push("clr_a_rbusy", A_RBUSY, 64'd0);
    push("clr_a_cnt", A_CNT, 64'd0);
    push("clr_b_rbusy", B_RBUSY, 64'd0);
    push("clr_b_rd1", B_RD1, 64'h33);
    push("clr_b_cnt", B_CNT, 64'd0);
    check_neg();
    tick();

    // Issue and writeback to the same register in one cycle: issue wins, data lands
    a_issue_valid = 1'b1; a_issue_rd = 5'd9; a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h99;
    b_issue_valid = 1'b1; b_issue_rd = 4'd9; b_we = 1'b1; b_waddr = 4'd9;
    b_wdata = 64'h9999_0000_0000_0099;
    tick();
    idle_all();
    a_raddr = {5'd0, 5'd9};
    b_raddr = {4'd0, 4'd0, 4'd9};
    push("race_a_rd0", A_RD0, 64'h99);
    push("race_a_rbusy", A_RBUSY, 64'h1);
    push("race_a_cnt", A_CNT, 64'd1);
    push("race_b_rd0", B_RD0, 64'h9999_0000_0000_0099);
    push("race_b_rbusy", B_RBUSY, 64'h1);
    push("race_b_cnt", B_CNT, 64'd1);
    check_neg();
    tick();
    a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h99;
    b_we = 1'b1; b_waddr = 4'd9; b_wdata = 64'h9999_0000_0000_0099;
    tick();
    idle_all();
    push("race_a_clr", A_CNT, 64'd0);
    push("race_b_clr", B_CNT, 64'd0);
    check_neg();
    tick();

    // Fill every architectural register, then flush alongside an issue
    for (int i = 1; i <= 31; i++) begin
      a_issue_valid = 1'b1;
      a_issue_rd    = 5'(i);
      b_issue_valid = (i <= 15);
      b_issue_rd    = 4'(i);
      push("fill_a_cnt", A_CNT, 64'(i - 1));
      push("fill_b_cnt", B_CNT, 64'((i - 1 > 15) ? 15 : i - 1));
      check_neg();
      tick();
    end
    idle_all();
    a_raddr = {5'd31, 5'd0};
    b_raddr = {4'd15, 4'd0, 4'd0};
    push("full_a_cnt", A_CNT, 64'd31);
    push("full_a_rbusy", A_RBUSY, 64'h2);
    push("full_b_cnt", B_CNT, 64'd15);
    push("full_b_rbusy", B_RBUSY, 64'h4);
    check_neg();
    tick();
    a_flush = 1'b1; a_issue_valid = 1'b1; a_issue_rd = 5'd4;
    b_flush = 1'b1; b_issue_valid = 1'b1; b_issue_rd = 4'd4;
    push("flush_a_cnt_pre", A_CNT, 64'd31);
    check_neg();
    tick();
    idle_all();
    a_raddr = {5'd4, 5'd31};
    b_raddr = {4'd4, 4'd15, 4'd1};
    push("flush_a_cnt", A_CNT, 64'd0);
    push("flush_a_rbusy", A_RBUSY, 64'd0);
    push("flush_b_cnt", B_CNT, 64'd0);
    push("flush_b_rbusy", B_RBUSY, 64'd0);
    check_neg();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
